wide_add_seq: RTL

Sequencing controller that performs WORDS×32-bit add or subtract by driving a single shared `rca32` (32-bit ripple-carry adder: ports s, cout, a, b, cin) one word per cycle, LSW first, chaining the carry through a register. Sits between a requester issuing wide operands with a start/done handshake and the existing adder datapath, which it instantiates unmodified.

---
 rtl/wide_add_seq_if.sv | 24 ++
 rtl/wide_add_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/wide_add_seq_if.sv
// Requester-side bundle for wide_add_seq: wide operands in, result and status out.
interface wide_add_seq_if #(
    parameter int unsigned WORDS = 4
) ();
    logic                  start;
    logic                  sub;
    logic [32*WORDS-1:0]   a;
    logic [32*WORDS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [32*WORDS-1:0]   sum;
    logic                  cout;
    logic                  overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/wide_add_seq.sv
// Multi-word add/subtract sequencer: one shared 32-bit ripple adder, LSW first,
// carry chained through a register; includes the unmodified rca32 datapath.
module rca32 (
    output logic [31:0] s,
    output logic        cout,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin
);
    logic [32:0] w_c;

    always_comb begin
        w_c    = '0;
        s      = '0;
        w_c[0] = cin;
        for (int unsigned i = 0; i < 32; i++) begin
            s[i]     = a[i] ^ b[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
        end
        cout = w_c[32];
    end
endmodule

module wide_add_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    wide_add_seq_if.slave  bus
);
    localparam int unsigned W    = 32 * WORDS;
    localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            r_state;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic              r_sub;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic [W-1:0]      r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              r_busy;
    logic              r_done;

    logic [31:0]       w_a_word;
    logic [31:0]       w_b_word;
    logic [31:0]       w_b_eff;
    logic [31:0]       w_s;
    logic              w_cout;
    logic              w_last;

    // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
    always_comb begin
        w_a_word = '0;
        w_b_word = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_word = r_a[32*i +: 32];
                w_b_word = r_b[32*i +: 32];
            end
        end
        w_b_eff = r_sub ? ~w_b_word : w_b_word;
    end

    assign w_last = (r_idx == IDXW'(WORDS - 1));

    rca32 u_rca (
        .s    (w_s),
        .cout (w_cout),
        .a    (w_a_word),
        .b    (w_b_eff),
        .cin  (r_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_sub   <= bus.sub;
                        r_idx   <= '0;
                        r_carry <= bus.sub;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < WORDS; i++) begin
                        if (r_idx == IDXW'(i)) begin
                            r_sum[32*i +: 32] <= w_s;
                        end
                    end
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDXW'(1);
                    if (w_last) begin
                        r_cout  <= w_cout;
                        r_ovf   <= (w_a_word[31] == w_b_eff[31]) && (w_s[31] != w_a_word[31]);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;
endmodule
